seq_response_checker: RTL

Synthesizable response checker for single-bit sequential DUTs, e.g. the D flip-flop. It samples the stimulus bit driven into a DUT and the DUT's output bit, predicts the output with a fixed-latency delay model, and counts mismatches over a programmed number of samples. It sits on the observing side of a DUT, opposite the stimulus generator, and reports a pass/fail verdict in silicon or in simulation without `$display` scraping.

---
 rtl/seq_response_checker_if.sv | 26 ++
 rtl/seq_response_checker.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seq_response_checker_if.sv
// Handshake bundle between a stimulus/observation harness and seq_response_checker.
// The checker side uses the slave modport; the harness side uses master.
interface seq_response_checker_if #(
  parameter int CNT_W = 16
) ();
  logic             start;
  logic             d_in;
  logic             q_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] sample_count;
  logic             first_err_valid;
  logic [CNT_W-1:0] first_err_idx;

  modport master (
    output start, d_in, q_in,
    input  busy, done, pass, err_count, sample_count, first_err_valid, first_err_idx
  );

  modport slave (
    input  start, d_in, q_in,
    output busy, done, pass, err_count, sample_count, first_err_valid, first_err_idx
  );
endinterface

// File: rtl/seq_response_checker.sv
// Predicts a single-bit sequential DUT's output with a LATENCY-deep delay line and counts mismatches.
// Define SEQ_CHK_FIRST_ERR_EN to build first-mismatch capture; otherwise first_err_* read as 0.
module seq_response_checker #(
  parameter int NUM_SAMPLES = 10,
  parameter int LATENCY     = 1,
  parameter int CNT_W       = 16
) (
  input logic                   clk,
  input logic                   rst,
  seq_response_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [3:0]       FILL_LAST = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t             state_r, state_next_s;
  logic [LATENCY-1:0] dline_r;
  logic [3:0]         fill_cnt_r, fill_cnt_next_s;
  logic [CNT_W-1:0]   err_count_r, err_count_next_s;
  logic [CNT_W-1:0]   sample_count_r, sample_count_next_s;
  logic               busy_r, busy_next_s;
  logic               done_r, done_next_s;
  logic               pass_r, pass_next_s;
  logic               start_run_s;
  logic               mismatch_s;

  assign start_run_s = bus.start && ((state_r == IDLE) || (state_r == DONE));
  assign mismatch_s  = (state_r == CHECK) && (bus.q_in != dline_r[LATENCY-1]);

  // Delay line runs in every state so the prediction is primed before a run starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dline_r <= {LATENCY{1'b0}};
    end else begin
      dline_r[0] <= bus.d_in;
      for (int i = 1; i < LATENCY; i++) begin
        dline_r[i] <= dline_r[i-1];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state, counter updates and next values of the registered status outputs.
  always_comb begin
    state_next_s        = state_r;
    fill_cnt_next_s     = fill_cnt_r;
    err_count_next_s    = err_count_r;
    sample_count_next_s = sample_count_r;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          fill_cnt_next_s     = 4'd0;
          err_count_next_s    = {CNT_W{1'b0}};
          sample_count_next_s = {CNT_W{1'b0}};
          // A one-stage line already holds the start-edge stimulus, so FILL is skipped.
          state_next_s        = (LATENCY == 1) ? CHECK : FILL;
        end else begin
          state_next_s = state_r;
        end
      end
      FILL: begin
        fill_cnt_next_s = fill_cnt_r + 4'd1;
        if (fill_cnt_r == FILL_LAST) begin
          state_next_s = CHECK;
        end else begin
          state_next_s = FILL;
        end
      end
      CHECK: begin
        sample_count_next_s = sample_count_r + CNT_W'(1);
        if (mismatch_s) begin
          err_count_next_s = err_count_r + CNT_W'(1);
        end else begin
          err_count_next_s = err_count_r;
        end
        if (sample_count_r == LAST_IDX) begin
          state_next_s = DONE;
        end else begin
          state_next_s = CHECK;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
    busy_next_s = (state_next_s == FILL) || (state_next_s == CHECK);
    done_next_s = (state_next_s == DONE);
    pass_next_s = done_next_s && (err_count_next_s == {CNT_W{1'b0}});
  end

  // Counters and status outputs, registered so they change only after the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt_r     <= 4'd0;
      err_count_r    <= {CNT_W{1'b0}};
      sample_count_r <= {CNT_W{1'b0}};
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      pass_r         <= 1'b0;
    end else begin
      fill_cnt_r     <= fill_cnt_next_s;
      err_count_r    <= err_count_next_s;
      sample_count_r <= sample_count_next_s;
      busy_r         <= busy_next_s;
      done_r         <= done_next_s;
      pass_r         <= pass_next_s;
    end
  end

  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.pass         = pass_r;
  assign bus.err_count    = err_count_r;
  assign bus.sample_count = sample_count_r;

`ifdef SEQ_CHK_FIRST_ERR_EN
  logic             first_err_valid_r;
  logic [CNT_W-1:0] first_err_idx_r;

  // First mismatch of a run is captured once and held until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_err_valid_r <= 1'b0;
      first_err_idx_r   <= {CNT_W{1'b0}};
    end else if (start_run_s) begin
      first_err_valid_r <= 1'b0;
      first_err_idx_r   <= {CNT_W{1'b0}};
    end else if (mismatch_s && !first_err_valid_r) begin
      first_err_valid_r <= 1'b1;
      first_err_idx_r   <= sample_count_r;
    end else begin
      first_err_valid_r <= first_err_valid_r;
      first_err_idx_r   <= first_err_idx_r;
    end
  end

  assign bus.first_err_valid = first_err_valid_r;
  assign bus.first_err_idx   = first_err_idx_r;
`else
  logic unused_start_run_s;
  assign unused_start_run_s  = start_run_s;
  assign bus.first_err_valid = 1'b0;
  assign bus.first_err_idx   = {CNT_W{1'b0}};
`endif

endmodule
